// File: rtl/quadrature_generator_pkg.sv
// Shared definitions for the quadrature generator: FSM states, the
// per-direction Gray phase tables and the detent rest state.
package quadrature_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2,
        ST_FIN   = 2'd3
    } quad_state_t;

    // Both phases high: the detent rest position of a pulled-up encoder.
    localparam logic [1:0] PH_REST = 2'b11;

    // Gray phase tables as (A,B); entry 3 always lands back on the rest state.
    localparam logic [1:0] CW_SEQ_0  = 2'b01;
    localparam logic [1:0] CW_SEQ_1  = 2'b00;
    localparam logic [1:0] CW_SEQ_2  = 2'b10;
    localparam logic [1:0] CW_SEQ_3  = 2'b11;
    localparam logic [1:0] CCW_SEQ_0 = 2'b10;
    localparam logic [1:0] CCW_SEQ_1 = 2'b00;
    localparam logic [1:0] CCW_SEQ_2 = 2'b01;
    localparam logic [1:0] CCW_SEQ_3 = 2'b11;

    // Phase value for step idx (0..3) of a detent in the given direction.
    function automatic logic [1:0] phase_seq(input logic cw, input logic [1:0] idx);
        logic [1:0] ph;
        case (idx)
            2'd0:    ph = cw ? CW_SEQ_0 : CCW_SEQ_0;
            2'd1:    ph = cw ? CW_SEQ_1 : CCW_SEQ_1;
            2'd2:    ph = cw ? CW_SEQ_2 : CCW_SEQ_2;
            default: ph = cw ? CW_SEQ_3 : CCW_SEQ_3;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/quadrature_generator_dwell_timer.sv
// Reloadable down-counter that emits a single-cycle tick p_DWELL cycles
// after each load. Reusable for debounce and pacing.
module quad_dwell_timer #(
    parameter int p_DWELL = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic tick
);

    localparam int W = (p_DWELL > 2) ? $clog2(p_DWELL) : 1;
    localparam logic [W-1:0] RELOAD = W'(p_DWELL - 1);

    logic [W-1:0] cnt;
    logic         armed;

    // Tick only once per load; the armed flag stops a parked zero from re-firing.
    assign tick = armed && (cnt == '0);

    // Count down from p_DWELL-1 after a load; a load on the tick cycle re-arms.
    always_ff @(posedge CLK) begin
        if (RST) begin
            armed <= 1'b0;
        end else if (load) begin
            armed <= 1'b1;
            cnt   <= RELOAD;
        end else begin
            if (tick) begin
                armed <= 1'b0;
            end
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/quadrature_generator.sv
// Quadrature (A/B) encoder emulator: emits p_CNT_W-counted detents in either
// direction, spaced p_DWELL cycles per transition, with optional injection
// of one illegal double-toggle at command start.
module quadrature_generator
    import quadrature_generator_pkg::*;
#(
    parameter int p_DWELL = 1000,
    parameter int p_CNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_step_valid,
    input  logic               i_step_cw,
    input  logic [p_CNT_W-1:0] i_step_cnt,
    input  logic               i_step_err,
    output logic               o_step_ready,
    output logic               o_phase_a,
    output logic               o_phase_b,
    output logic               o_busy,
    output logic               o_done
);

    quad_state_t        state;
    logic [1:0]         phase;
    logic [1:0]         seq_idx;
    logic [p_CNT_W-1:0] detents_left;
    logic               cmd_cw;
    logic               accept;
    logic               tick;
    logic               timer_load;

    assign accept    = i_step_valid && o_step_ready;
    assign o_phase_a = phase[1];
    assign o_phase_b = phase[0];

    // Restart the dwell interval on every emitted transition, including the first.
    always_comb begin
        timer_load = 1'b0;
        if (accept && (i_step_cnt != '0)) begin
            timer_load = 1'b1;
        end else if ((state == ST_RUN) && tick) begin
            timer_load = 1'b1;
        end
    end

    quad_dwell_timer #(
        .p_DWELL (p_DWELL)
    ) u_dwell (
        .CLK  (CLK),
        .RST  (RST),
        .load (timer_load),
        .tick (tick)
    );

    // Command FSM with registered phase/handshake outputs; FIN doubles as an
    // accept slot so commands can run back-to-back.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            phase        <= PH_REST;
            o_step_ready <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE, ST_FIN: begin
                    state        <= ST_IDLE;
                    o_step_ready <= 1'b1;
                    o_busy       <= 1'b0;
                    if (accept) begin
                        cmd_cw <= i_step_cw;
                        if (i_step_cnt == '0) begin
                            // Empty command: complete immediately, error flag ignored.
                            state  <= ST_FIN;
                            o_done <= 1'b1;
                        end else begin
                            state        <= ST_RUN;
                            o_step_ready <= 1'b0;
                            o_busy       <= 1'b1;
                            detents_left <= i_step_cnt;
                            if (i_step_err) begin
                                // Jump straight to 00, then resume the detent at step 2.
                                phase   <= 2'b00;
                                seq_idx <= 2'd2;
                            end else begin
                                phase   <= phase_seq(i_step_cw, 2'd0);
                                seq_idx <= 2'd1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        phase   <= phase_seq(cmd_cw, seq_idx);
                        seq_idx <= seq_idx + 2'd1;
                        if (seq_idx == 2'd3) begin
                            detents_left <= detents_left - 1'b1;
                            if (detents_left == {{(p_CNT_W-1){1'b0}}, 1'b1}) begin
                                state <= ST_GUARD;
                            end
                        end
                    end
                end
                ST_GUARD: begin
                    if (tick) begin
                        state        <= ST_FIN;
                        o_done       <= 1'b1;
                        o_step_ready <= 1'b1;
                        o_busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
